// File: rtl/uart_tx_fifo_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_feeder
//
// Purpose:
//   Byte FIFO plus a small transmit sequencer that sits directly in front of
//   a UART transmitter. Bursts of single-cycle byte strobes are absorbed into
//   the FIFO. The bytes are then handed to UART_TX one at a time through its
//   DV / Active / Done handshake.
//
// Ports:
//   CLK          system clock; all logic on the rising edge
//   RST          synchronous, active-high reset
//   i_Wr_DV      single-cycle push strobe
//   i_Wr_Byte    byte to push, sampled when i_Wr_DV=1
//   o_TX_DV      single-cycle strobe to UART_TX i_TX_DV
//   o_TX_Byte    byte to UART_TX; held until the next strobe
//   i_TX_Active  UART_TX o_TX_Active
//   i_TX_Done    UART_TX o_TX_Done (one-cycle pulse)
//   o_Count      occupancy, 0..DEPTH
//   o_Empty      o_Count == 0
//   o_Full       o_Count == DEPTH
//   o_Overflow   sticky flag: a write was dropped; cleared only by RST
//
// Optional feature (macro UART_TX_FIFO_CRLF_EN):
//   When it is defined, every transmitted 0x0D is followed automatically by a
//   0x0A. The inserted 0x0A does not occupy a FIFO entry. When it is not
//   defined, 0x0D is sent like any other byte.
// ---------------------------------------------------------------------------
module uart_tx_fifo_feeder #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_Wr_DV,
    input  logic [DATA_WIDTH-1:0] i_Wr_Byte,
    output logic                  o_TX_DV,
    output logic [DATA_WIDTH-1:0] o_TX_Byte,
    input  logic                  i_TX_Active,
    input  logic                  i_TX_Done,
    output logic [ADDR_WIDTH:0]   o_Count,
    output logic                  o_Empty,
    output logic                  o_Full,
    output logic                  o_Overflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
`ifdef UART_TX_FIFO_CRLF_EN
    localparam logic [DATA_WIDTH-1:0] CR_BYTE = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] LF_BYTE = DATA_WIDTH'(8'h0A);
`endif

    // SEND is the single cycle in which the strobe is presented. BUSY then
    // waits for Done, and o_TX_DV stays low for the whole of BUSY.
`ifdef UART_TX_FIFO_CRLF_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_BUSY, ST_LF} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_BUSY} state_t;
`endif

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]   tx_byte_q, tx_byte_d;

    logic                    pop;
    logic                    lf_load;
    logic                    full;
    logic                    wr_acc;
    logic                    wr_drop;
    logic [DATA_WIDTH-1:0]   mem_rd_data;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // -----------------------------------------------------------------------
    // Storage. The array is not reset. Old contents become unreachable once
    // the pointers clear.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST && wr_acc) begin
            mem[wr_ptr_q] <= i_Wr_Byte;
        end
    end

    // The head read is only used on a pop. tx_byte_q registers it. At full,
    // the write and read addresses coincide. The pop still gets the old head
    // because the array write only takes effect after this edge.
    assign mem_rd_data = mem[rd_ptr_q];

    // -----------------------------------------------------------------------
    // FSM process 1: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next state and pop decision.
    // The pop looks only at the registered count. A byte written this cycle
    // therefore cannot leave in the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        lf_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((count_q != '0) && !i_TX_Active) begin
                    pop     = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (i_TX_Done) begin
`ifdef UART_TX_FIFO_CRLF_EN
                    state_d = (tx_byte_q == CR_BYTE) ? ST_LF : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef UART_TX_FIFO_CRLF_EN
            ST_LF: begin
                // Wait for the transmitter to go idle before sending the LF.
                if (!i_TX_Active) begin
                    lf_load = 1'b1;
                    state_d = ST_SEND;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        o_TX_DV = (state_q == ST_SEND);
    end

    // -----------------------------------------------------------------------
    // FIFO datapath
    // -----------------------------------------------------------------------
    assign full = (count_q == DEPTH_CNT);

    always_comb begin
        // A write into a full FIFO is allowed only when a pop frees a slot in
        // the same cycle.
        wr_acc  = i_Wr_DV && (!full || pop);
        wr_drop = i_Wr_DV && full && !pop;

        wr_ptr_d = wr_acc ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop    ? (rd_ptr_q + 1'b1) : rd_ptr_q;

        count_d = count_q;
        case ({wr_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q | wr_drop;

        tx_byte_d = tx_byte_q;
        if (pop) begin
            tx_byte_d = mem_rd_data;
        end
`ifdef UART_TX_FIFO_CRLF_EN
        else if (lf_load) begin
            tx_byte_d = LF_BYTE;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_byte_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    assign o_TX_Byte  = tx_byte_q;
    assign o_Count    = count_q;
    assign o_Empty    = (count_q == '0);
    assign o_Full     = full;
    assign o_Overflow = overflow_q;

    // In the default build, lf_load is never set. It is tied off here so that
    // both builds use the same datapath signal list.
`ifndef UART_TX_FIFO_CRLF_EN
    logic unused_lf;
    assign unused_lf = lf_load;
`endif

endmodule
